// File: rtl/fmsg_rx_decoder_if.sv
// Stream and status bundle between the fmsg link receiver, the decoder and the dispatch logic.
// slave = decoder side; master = the link/dispatch/statistics side.
interface fmsg_rx_decoder_if #(
    parameter int TYPE_W    = 2,
    parameter int DEST_W    = 2,
    parameter int PAYLOAD_W = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8
);
    localparam int MSG_W = TYPE_W + DEST_W + PAYLOAD_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [MSG_W-1:0]     in_fmsg;
    logic                 in_valid;
    logic                 in_ready;
    logic [TYPE_W-1:0]    out_type;
    logic [DEST_W-1:0]    out_dest;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_bcast;
    logic                 out_valid;
    logic                 out_ready;
    logic                 clr_cnt;
    logic [CNT_W-1:0]     acc_cnt;
    logic [CNT_W-1:0]     drop_cnt;
    logic [LVL_W-1:0]     fifo_level;

    modport slave (
        input  in_fmsg, in_valid, out_ready, clr_cnt,
        output in_ready, out_type, out_dest, out_payload, out_bcast, out_valid,
               acc_cnt, drop_cnt, fifo_level
    );

    modport master (
        output in_fmsg, in_valid, out_ready, clr_cnt,
        input  in_ready, out_type, out_dest, out_payload, out_bcast, out_valid,
               acc_cnt, drop_cnt, fifo_level
    );
endinterface

// File: rtl/fmsg_rx_decoder.sv
// Splits fmsg words into TYPE/DEST/PAYLOAD, queues words for this node (or broadcast) in a FIFO.
// Latency 1 cycle in->out; in_ready drops only when the FIFO is full; saturating accept/drop stats.
module fmsg_rx_decoder #(
    parameter int TYPE_W    = 2,
    parameter int DEST_W    = 2,
    parameter int PAYLOAD_W = 4,
    parameter int MY_DEST   = 0,
    parameter int BCAST_EN  = 1,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    fmsg_rx_decoder_if.slave bus
);
    localparam int MSG_W = TYPE_W + DEST_W + PAYLOAD_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [DEST_W-1:0] MY_ADDR   = DEST_W'(MY_DEST);
    localparam logic [DEST_W-1:0] DEST_ONES = '1;
    // A node whose own address is all ones sees all-ones traffic as plain unicast.
    localparam bit BC_OK = (BCAST_EN != 0) && (MY_ADDR != DEST_ONES);

    typedef struct packed {
        logic                 bcast;
        logic [TYPE_W-1:0]    typ;
        logic [DEST_W-1:0]    dst;
        logic [PAYLOAD_W-1:0] pay;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    entry_t in_ent;
    entry_t head;
    logic   is_ucast;
    logic   is_bcast;
    logic   in_rdy;
    logic   out_vld;
    logic   push;
    logic   drop;
    logic   pop;

    always_comb begin
        in_ent.typ   = bus.in_fmsg[MSG_W-1 -: TYPE_W];
        in_ent.dst   = bus.in_fmsg[PAYLOAD_W +: DEST_W];
        in_ent.pay   = bus.in_fmsg[PAYLOAD_W-1:0];
        is_ucast     = (in_ent.dst == MY_ADDR);
        is_bcast     = BC_OK && (in_ent.dst == DEST_ONES);
        in_ent.bcast = is_bcast;

        in_rdy  = (level_q != LVL_W'(DEPTH));
        out_vld = (level_q != '0);
        push    = bus.in_valid && in_rdy && (is_ucast || is_bcast);
        drop    = bus.in_valid && in_rdy && !(is_ucast || is_bcast);
        pop     = out_vld && bus.out_ready;

        wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop  ? rd_q + PTR_W'(1) : rd_q;
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        acc_d = acc_q;
        if (bus.clr_cnt)
            acc_d = '0;
        else if (push && (acc_q != '1))
            acc_d = acc_q + CNT_W'(1);

        drop_d = drop_q;
        if (bus.clr_cnt)
            drop_d = '0;
        else if (drop && (drop_q != '1))
            drop_d = drop_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: contents are only visible through out_vld.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_q] <= in_ent;
    end

    assign head = out_vld ? mem_q[rd_q] : '0;

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.out_type    = head.typ;
    assign bus.out_dest    = head.dst;
    assign bus.out_payload = head.pay;
    assign bus.out_bcast   = head.bcast;
    assign bus.acc_cnt     = acc_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.fifo_level  = level_q;
endmodule

// File: tb/tb_fmsg_rx_decoder.sv
// Directed bench: a table of per-cycle vectors for the default node, plus hand sequences for
// the no-broadcast variant, counter saturation/clear and reset with a loaded FIFO.
module tb_fmsg_rx_decoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fmsg_rx_decoder_if #(.TYPE_W(2), .DEST_W(2), .PAYLOAD_W(4), .DEPTH(4), .CNT_W(8)) bus0 ();
    fmsg_rx_decoder_if #(.TYPE_W(2), .DEST_W(2), .PAYLOAD_W(4), .DEPTH(4), .CNT_W(8)) bus1 ();

    fmsg_rx_decoder #(.TYPE_W(2), .DEST_W(2), .PAYLOAD_W(4), .MY_DEST(0), .BCAST_EN(1),
                      .DEPTH(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    fmsg_rx_decoder #(.TYPE_W(2), .DEST_W(2), .PAYLOAD_W(4), .MY_DEST(0), .BCAST_EN(0),
                      .DEPTH(4), .CNT_W(8)) u_dut_nobc (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        bit       rst;
        bit       vld;
        bit [7:0] msg;
        bit       ordy;
        bit       clr;
        int       ir;
        int       ov;
        int       ty;
        int       de;
        int       pa;
        int       bc;
        int       lvl;
        int       acc;
        int       drp;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit v, bit [7:0] m, bit o, bit c,
                                int ir, int ov, int ty, int de, int pa, int bc,
                                int lvl, int acc, int drp);
        vec_t x;
        x.rst = r; x.vld = v; x.msg = m; x.ordy = o; x.clr = c;
        x.ir = ir; x.ov = ov; x.ty = ty; x.de = de; x.pa = pa; x.bc = bc;
        x.lvl = lvl; x.acc = acc; x.drp = drp;
        return x;
    endfunction

    task automatic drive0(bit r, bit v, bit [7:0] m, bit o, bit c);
        rst           = r;
        bus0.in_valid = v;
        bus0.in_fmsg  = m;
        bus0.out_ready = o;
        bus0.clr_cnt  = c;
    endtask

    task automatic check_head0(string nm, int ir, int ov, int ty, int de, int pa, int bc,
                               int lvl, int acc, int drp);
        chk({nm, ".in_ready"},   int'(bus0.in_ready),    ir);
        chk({nm, ".out_valid"},  int'(bus0.out_valid),   ov);
        chk({nm, ".out_type"},   int'(bus0.out_type),    ty);
        chk({nm, ".out_dest"},   int'(bus0.out_dest),    de);
        chk({nm, ".out_payload"},int'(bus0.out_payload), pa);
        chk({nm, ".out_bcast"},  int'(bus0.out_bcast),   bc);
        chk({nm, ".fifo_level"}, int'(bus0.fifo_level),  lvl);
        chk({nm, ".acc_cnt"},    int'(bus0.acc_cnt),     acc);
        chk({nm, ".drop_cnt"},   int'(bus0.drop_cnt),    drp);
    endtask

    initial begin
        //            rst vld msg   rdy clr  ir ov ty de pa bc lvl acc drp
        vt[0]  = mk(1, 1, 8'h45, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);  // handshake under reset ignored
        vt[1]  = mk(0, 1, 8'hA3, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1);  // DEST=2 dropped
        vt[2]  = mk(0, 1, 8'h45, 0, 0,   1, 1, 1, 0, 5, 0, 1, 1, 1);
        vt[3]  = mk(0, 1, 8'hF7, 1, 0,   1, 1, 3, 3, 7, 1, 1, 2, 1);  // broadcast in, 0x45 out
        vt[4]  = mk(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 0, 0, 0, 2, 1);
        vt[5]  = mk(0, 1, 8'h01, 0, 0,   1, 1, 0, 0, 1, 0, 1, 3, 1);
        vt[6]  = mk(0, 1, 8'h02, 0, 0,   1, 1, 0, 0, 1, 0, 2, 4, 1);
        vt[7]  = mk(0, 1, 8'h03, 0, 0,   1, 1, 0, 0, 1, 0, 3, 5, 1);
        vt[8]  = mk(0, 1, 8'h04, 0, 0,   0, 1, 0, 0, 1, 0, 4, 6, 1);  // full
        vt[9]  = mk(0, 1, 8'h05, 0, 0,   0, 1, 0, 0, 1, 0, 4, 6, 1);  // 5th word stalls
        vt[10] = mk(0, 1, 8'h05, 1, 0,   1, 1, 0, 0, 2, 0, 3, 6, 1);  // pop while full, no push
        vt[11] = mk(0, 1, 8'h05, 0, 0,   0, 1, 0, 0, 2, 0, 4, 7, 1);  // 5th word now taken
        vt[12] = mk(0, 0, 8'h00, 1, 0,   1, 1, 0, 0, 3, 0, 3, 7, 1);
        vt[13] = mk(0, 0, 8'h00, 1, 0,   1, 1, 0, 0, 4, 0, 2, 7, 1);
        vt[14] = mk(0, 1, 8'h06, 1, 0,   1, 1, 0, 0, 5, 0, 2, 8, 1);  // push+pop at level 2
        vt[15] = mk(0, 0, 8'h00, 1, 0,   1, 1, 0, 0, 6, 0, 1, 8, 1);
        vt[16] = mk(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 0, 0, 0, 8, 1);
        vt[17] = mk(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 0, 0, 0, 8, 1);  // pop while empty ignored
        vt[18] = mk(0, 1, 8'h9C, 0, 0,   1, 0, 0, 0, 0, 0, 0, 8, 2);  // DEST=1 dropped
        vt[19] = mk(0, 1, 8'h89, 0, 1,   1, 1, 2, 0, 9, 0, 1, 0, 0);  // clear beats push count
        vt[20] = mk(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);

        bus1.in_valid = 1'b0; bus1.in_fmsg = 8'h00; bus1.out_ready = 1'b0; bus1.clr_cnt = 1'b0;
        drive0(1, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        check_head0("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive0(vt[i].rst, vt[i].vld, vt[i].msg, vt[i].ordy, vt[i].clr);
            @(posedge clk); #1;
            check_head0($sformatf("v%0d", i), vt[i].ir, vt[i].ov, vt[i].ty, vt[i].de,
                        vt[i].pa, vt[i].bc, vt[i].lvl, vt[i].acc, vt[i].drp);
        end
        drive0(0, 0, 8'h00, 0, 0);

        // Broadcast disabled: 0xF7 is filtered, 0x45 still accepted.
        bus1.in_valid = 1'b1; bus1.in_fmsg = 8'hF7;
        @(posedge clk); #1;
        chk("nobc.drop_cnt",  int'(bus1.drop_cnt),  1);
        chk("nobc.acc_cnt",   int'(bus1.acc_cnt),   0);
        chk("nobc.out_valid", int'(bus1.out_valid), 0);
        bus1.in_fmsg = 8'h45;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("nobc2.out_valid",   int'(bus1.out_valid),   1);
        chk("nobc2.out_payload", int'(bus1.out_payload), 5);
        chk("nobc2.out_bcast",   int'(bus1.out_bcast),   0);
        chk("nobc2.acc_cnt",     int'(bus1.acc_cnt),     1);

        // 300 matching pushes with the consumer always ready: acc saturates at 255.
        for (int i = 0; i < 300; i++) begin
            drive0(0, 1, 8'h4A, 1, 0);
            @(posedge clk); #1;
            if (i == 254) chk("sat.acc_at_255", int'(bus0.acc_cnt), 255);
        end
        chk("sat.acc_cnt",    int'(bus0.acc_cnt),    255);
        chk("sat.drop_cnt",   int'(bus0.drop_cnt),   0);
        chk("sat.fifo_level", int'(bus0.fifo_level), 1);
        chk("sat.in_ready",   int'(bus0.in_ready),   1);
        drive0(0, 1, 8'h4B, 1, 1);
        @(posedge clk); #1;
        chk("satclr.acc_cnt",     int'(bus0.acc_cnt),     0);
        chk("satclr.out_payload", int'(bus0.out_payload), 11);
        chk("satclr.fifo_level",  int'(bus0.fifo_level),  1);
        drive0(0, 0, 8'h00, 1, 0);
        @(posedge clk); #1;
        chk("drain.out_valid", int'(bus0.out_valid), 0);

        // Reset with three entries queued and a matching handshake in the same cycle.
        for (int i = 1; i <= 3; i++) begin
            drive0(0, 1, 8'(8'h30 + i), 0, 0);
            @(posedge clk); #1;
        end
        chk("load.fifo_level", int'(bus0.fifo_level), 3);
        chk("load.out_dest",   int'(bus0.out_dest),   3);
        chk("load.out_bcast",  int'(bus0.out_bcast),  1);
        drive0(1, 1, 8'h47, 0, 0);
        @(posedge clk); #1;
        check_head0("rst3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive0(0, 0, 8'h00, 1, 0);
        @(posedge clk); #1;
        check_head0("postrst", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
